// File: rtl/bank_mem_responder_pkg.sv
// Shared definitions for the banked coefficient memory responder:
// default widths, FSM state encodings and access-mode encoding.
package bank_mem_responder_pkg;

    localparam int BANK_W_DEF = 4;
    localparam int MA_W_DEF   = 6;
    localparam int DATA_W_DEF = 32;
    localparam int TOTAL_DEF  = 1024;
    localparam int CNT_W_DEF  = 11;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_RUN   = 2'd1;
    localparam state_t ST_DRAIN = 2'd2;
    localparam state_t ST_DONE  = 2'd3;

    localparam logic MODE_LOAD  = 1'b1;
    localparam logic MODE_FETCH = 1'b0;

endpackage

// File: rtl/bank_sram.sv
// Single-port coefficient bank: synchronous write, registered read.
// The read register holds its value whenever no read is issued.
module bank_sram
    import bank_mem_responder_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = MA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rdata;

    // NOTE: the storage array is deliberately left out of reset so it maps onto SRAM macros;
    // only the read-data register is reset.
    always_ff @(posedge clk) begin
        if (en && we) begin
            r_mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (en && !we) begin
            r_rdata <= r_mem[addr];
        end
    end

    assign rdata = r_rdata;

endmodule

// File: rtl/bank_mem_responder.sv
// Banked coefficient memory fed by the AGU (BN_idx, MA_idx) stream; loads or fetches
// one TOTAL-access pass. Optional bank-conflict checking under BANK_CONFLICT_CHK_EN.
module bank_mem_responder
    import bank_mem_responder_pkg::*;
#(
    parameter int BANK_W = BANK_W_DEF,
    parameter int MA_W   = MA_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int TOTAL  = TOTAL_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic              BN_MA_in_en,
    input  logic [BANK_W-1:0] BN_idx,
    input  logic [MA_W-1:0]   MA_idx,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              busy,
    output logic              done_out,
    output logic              conflict_err
);

    localparam int NUM_BANK = 2**BANK_W;

    state_t            r_state;
    logic              r_mode;
    logic [CNT_W-1:0]  r_acc_cnt;
    logic              r_rd_valid;
    logic [BANK_W-1:0] r_rd_bank;

    logic              w_start_ok;
    logic              w_accept;
    logic              w_last;
    logic [DATA_W-1:0] w_bank_rdata [NUM_BANK];

    assign w_start_ok = (r_state == ST_IDLE) && start;
    assign w_accept   = (r_state == ST_RUN) && BN_MA_in_en;
    assign w_last     = w_accept && (r_acc_cnt == CNT_W'(TOTAL - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_mode    <= MODE_FETCH;
            r_acc_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_mode    <= mode;
                        r_acc_cnt <= '0;
                        r_state   <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (w_accept) begin
                        r_acc_cnt <= r_acc_cnt + 1'b1;
                    end
                    // A fetch pass needs one extra cycle to present the final read.
                    if (w_last) begin
                        r_state <= (r_mode == MODE_LOAD) ? ST_DONE : ST_DRAIN;
                    end
                end
                ST_DRAIN: r_state <= ST_DONE;
                default:  r_state <= ST_IDLE;
            endcase
        end
    end

    // The bank selector only moves on a fetch, so rd_data holds between reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            r_rd_bank  <= '0;
        end else begin
            r_rd_valid <= w_accept && (r_mode == MODE_FETCH);
            if (w_accept && (r_mode == MODE_FETCH)) begin
                r_rd_bank <= BN_idx;
            end
        end
    end

    for (genvar g = 0; g < NUM_BANK; g++) begin : g_bank
        logic w_en;
        assign w_en = w_accept && (BN_idx == BANK_W'(g));

        bank_sram #(
            .DATA_W (DATA_W),
            .ADDR_W (MA_W)
        ) u_bank (
            .clk   (clk),
            .rst   (rst),
            .en    (w_en),
            .we    (r_mode == MODE_LOAD),
            .addr  (MA_idx),
            .wdata (wr_data),
            .rdata (w_bank_rdata[g])
        );
    end

    assign rd_data  = w_bank_rdata[r_rd_bank];
    assign rd_valid = r_rd_valid;
    assign busy     = (r_state == ST_RUN) || (r_state == ST_DRAIN);
    assign done_out = (r_state == ST_DONE);

`ifdef BANK_CONFLICT_CHK_EN
    logic [NUM_BANK-1:0] r_used_mask;
    logic                r_conflict;
    logic [NUM_BANK-1:0] w_mask_base;
    logic [NUM_BANK-1:0] w_bn_onehot;

    // Each group of NUM_BANK accesses starts with an empty used-bank mask.
    always_comb begin
        w_mask_base = (r_acc_cnt[BANK_W-1:0] == '0) ? '0 : r_used_mask;
        w_bn_onehot = NUM_BANK'(1) << BN_idx;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_used_mask <= '0;
            r_conflict  <= 1'b0;
        end else if (w_start_ok) begin
            r_used_mask <= '0;
            r_conflict  <= 1'b0;
        end else if (w_accept) begin
            r_used_mask <= w_mask_base | w_bn_onehot;
            if (|(w_mask_base & w_bn_onehot)) begin
                r_conflict <= 1'b1;
            end
        end
    end

    assign conflict_err = r_conflict;
`else
    logic w_unused;
    assign w_unused     = w_start_ok;
    assign conflict_err = 1'b0;
`endif

endmodule

// File: tb/tb_bank_mem_responder.sv
// Directed self-checking bench for bank_mem_responder with a read-data scoreboard.
module tb_bank_mem_responder;

    localparam int TOTAL = 1024;
`ifdef BANK_CONFLICT_CHK_EN
    localparam logic EXP_CONF = 1'b1;
`else
    localparam logic EXP_CONF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        mode;
    logic        BN_MA_in_en;
    logic [3:0]  BN_idx;
    logic [5:0]  MA_idx;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic        busy;
    logic        done_out;
    logic        conflict_err;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_done   = 0;
    int          d0;
    logic [31:0] exp_q [$];
    logic [31:0] model [16][64];

    bank_mem_responder dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .mode         (mode),
        .BN_MA_in_en  (BN_MA_in_en),
        .BN_idx       (BN_idx),
        .MA_idx       (MA_idx),
        .wr_data      (wr_data),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .busy         (busy),
        .done_out     (done_out),
        .conflict_err (conflict_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every rd_valid pops the oldest expected coefficient.
    always @(negedge clk) begin
        if (!rst && rd_valid) begin
            if (exp_q.size() == 0) check("rd_valid_unexpected", {31'd0, rd_valid}, 32'd0);
            else check("rd_data", rd_data, exp_q.pop_front());
        end
        if (!rst && done_out) n_done++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic en, input int bn, input int ma, input logic [31:0] wd);
        BN_MA_in_en = en;
        BN_idx      = 4'(bn);
        MA_idx      = 6'(ma);
        wr_data     = wd;
        @(posedge clk); #1;
        BN_MA_in_en = 1'b0;
    endtask

    task automatic start_pass(input logic m);
        start = 1'b1;
        mode  = m;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic fetch_access(input int bn, input int ma);
        exp_q.push_back(model[bn][ma]);
        drive(1'b1, bn, ma, 32'hDEAD_BEEF);
    endtask

    task automatic fetch_tail(input string tag);
        check({tag, "_drain_done"}, {31'd0, done_out}, 32'd0);
        check({tag, "_drain_busy"}, {31'd0, busy}, 32'd1);
        check({tag, "_drain_valid"}, {31'd0, rd_valid}, 32'd1);
        drive(1'b0, 0, 0, 0);
        check({tag, "_done_pulse"}, {31'd0, done_out}, 32'd1);
        check({tag, "_done_busy"}, {31'd0, busy}, 32'd0);
        drive(1'b0, 0, 0, 0);
        check({tag, "_done_cleared"}, {31'd0, done_out}, 32'd0);
        check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic load_pass(input int n, input logic [31:0] base);
        start_pass(1'b1);
        for (int i = 0; i < n; i++) begin
            drive(1'b1, i % 16, (i / 16) % 64, base | 32'(i));
            if (i < TOTAL) model[i % 16][(i / 16) % 64] = base | 32'(i);
            if (i == TOTAL - 1) begin
                check("load_done_pulse", {31'd0, done_out}, 32'd1);
                check("load_done_busy", {31'd0, busy}, 32'd0);
            end
        end
        drive(1'b0, 0, 0, 0);
        check("load_done_cleared", {31'd0, done_out}, 32'd0);
    endtask

    task automatic fetch_pass(input string tag);
        start_pass(1'b0);
        for (int i = 0; i < TOTAL; i++) fetch_access(i % 16, i / 16);
        fetch_tail(tag);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mode = 1'b0;
        BN_MA_in_en = 1'b0; BN_idx = '0; MA_idx = '0; wr_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done_out}, 32'd0);
        check("rst_conflict", {31'd0, conflict_err}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Load then fetch with data = linear access index.
        d0 = n_done;
        load_pass(TOTAL, 32'd0);
        check("load_done_count", 32'(n_done - d0), 32'd1);
        d0 = n_done;
        fetch_pass("fetch1");
        check("fetch1_done_count", 32'(n_done - d0), 32'd1);
        check("fetch1_no_conflict", {31'd0, conflict_err}, 32'd0);

        // Gaps in the access stream.
        d0 = n_done;
        start_pass(1'b0);
        for (int i = 0; i < TOTAL; i++) begin
            if (i == TOTAL - 1) check("gap_busy_before_last", {31'd0, busy}, 32'd1);
            fetch_access(i % 16, i / 16);
            if (i < 2) begin
                check("gap_valid_hi", {31'd0, rd_valid}, 32'd1);
                check("gap_data", rd_data, 32'(i));
            end
            if (i < 2 || i % 7 == 0) begin
                drive(1'b0, 0, 0, 0);
                if (i < 2) begin
                    check("gap_valid_lo", {31'd0, rd_valid}, 32'd0);
                    check("gap_data_hold", rd_data, 32'(i));
                end
            end
        end
        fetch_tail("gap");
        check("gap_done_count", 32'(n_done - d0), 32'd1);

        // Start pulse and mode flip while running must be ignored.
        d0 = n_done;
        start_pass(1'b0);
        for (int i = 0; i < TOTAL; i++) begin
            if (i == 10) begin
                start = 1'b1;
                mode  = 1'b1;
            end
            fetch_access(i % 16, i / 16);
            start = 1'b0;
        end
        fetch_tail("midstart");
        check("midstart_done_count", 32'(n_done - d0), 32'd1);
        mode = 1'b0;

        // Group 0 reuses bank 3 on its 16th access.
        d0 = n_done;
        start_pass(1'b0);
        for (int i = 0; i < 16; i++) begin
            fetch_access((i < 15) ? i : 3, 0);
            if (i == 14) check("conf_before", {31'd0, conflict_err}, 32'd0);
        end
        check("conf_set", {31'd0, conflict_err}, {31'd0, EXP_CONF});
        for (int i = 16; i < TOTAL; i++) fetch_access(i % 16, i / 16);
        fetch_tail("conf");
        check("conf_sticky", {31'd0, conflict_err}, {31'd0, EXP_CONF});
        check("conf_done_count", 32'(n_done - d0), 32'd1);

        // Reset in the middle of a load pass.
        start_pass(1'b1);
        check("conf_cleared_by_start", {31'd0, conflict_err}, 32'd0);
        for (int i = 0; i <= 500; i++) drive(1'b1, i % 16, i / 16, 32'(i));
        #2 rst = 1'b1;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_rd_data", rd_data, 32'd0);
        check("midrst_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("midrst_done", {31'd0, done_out}, 32'd0);
        check("midrst_conflict", {31'd0, conflict_err}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        d0 = n_done;
        load_pass(TOTAL, 32'd0);
        check("postrst_done_count", 32'(n_done - d0), 32'd1);

        // Accesses beyond TOTAL must not write.
        d0 = n_done;
        load_pass(TOTAL + 6, 32'h5A5A_0000);
        check("extra_done_count", 32'(n_done - d0), 32'd1);
        check("extra_idle_busy", {31'd0, busy}, 32'd0);
        d0 = n_done;
        fetch_pass("fetch2");
        check("fetch2_done_count", 32'(n_done - d0), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
